mips_mc_control: RTL

Moore-style main control FSM for the multicycle MIPS datapath. Decodes the instruction opcode and sequences one instruction over 3-5 cycles. Produces the per-cycle write enables that drive the enable inputs of the datapath's enabled registers (PC, IR, register-file write port, memory) and the mux/ALU selects. Sits directly upstream of those registers; its enables are the only sources of their `enable` pins.

---
 rtl/mips_mc_control.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: one instruction in 2-5 cycles, Moore outputs decoded from the state register.
// Latency: outputs follow state combinationally (pc_en also follows zero); no backpressure, the FSM never stalls.
module mips_mc_control #(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    output logic               pc_en,
    output logic               ir_write,
    output logic               reg_write,
    output logic               mem_write,
    output logic               iord,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   pc_write, branch;

    always_comb begin
        state_d   = FETCH;
        illegal_d = illegal_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_d = MEMWB;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            // Terminal states and the unused codes 12-15 all restart at FETCH.
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        case (state_q)
            FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
            end
            DECODE: alu_src_b = 2'b11;
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ADDIWB: reg_write = 1'b1;
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                branch    = 1'b1;
                pc_src    = 2'b01;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            default: ;
        endcase
    end

    assign pc_en      = pc_write | (branch & zero);
    assign illegal_op = illegal_q;
    assign state      = STATE_W'(state_q);

endmodule
